// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC generation, 1-cycle memory read return,
// and a small FIFO toward decode with redirect flush.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [31:0]   r_pc;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;
    logic [31:0]   r_q_instr [DEPTH];
    logic [31:0]   r_q_pc [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_last_instr;
    logic [31:0]   r_last_pc;

    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [CW:0]   w_demand;
    logic [31:0]   w_redirect_tgt;
    logic [31:0]   w_head_instr;
    logic [31:0]   w_head_pc;

    assign w_redirect_tgt = redirect_pc & ~32'h3;
    assign w_head_instr   = r_q_instr[r_rd_ptr];
    assign w_head_pc      = r_q_pc[r_rd_ptr];

    assign mem_addr    = r_pc;
    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? w_head_instr : r_last_instr;
    assign instr_pc    = instr_valid ? w_head_pc : r_last_pc;

    assign w_pop  = instr_valid & instr_ready;
    assign w_push = r_inflight & ~redirect_valid;

    // Slot credit counts the entry leaving this same edge.
    assign w_demand = {1'b0, r_count}
                    + {{CW{1'b0}}, r_inflight}
                    - {{CW{1'b0}}, w_pop};
    assign w_issue  = fetch_en & ~redirect_valid
                    & (w_demand < (CW+1)'(DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_last_instr  <= '0;
            r_last_pc     <= '0;
        end else if (redirect_valid) begin
            r_pc       <= w_redirect_tgt;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + 32'd4;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + PW'(1);
                r_last_instr <= w_head_instr;
                r_last_pc    <= w_head_pc;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= mem_data;
            r_q_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_push && !w_pop && (r_count == CW'(DEPTH))));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, async reset case,
// and randomized traffic checked by an in-order stream model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    int tests = 0;
    int fails = 0;
    int accepts = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mw(input logic [31:0] a);
        case (a)
            32'h0:   return 32'hA000_00AA;
            32'h4:   return 32'h1000_0011;
            32'h8:   return 32'h2000_0022;
            32'hC:   return 32'h3000_0033;
            default: return a ^ 32'h5EED_0000;
        endcase
    endfunction

    // Registered-output memory: data for an address sampled at an edge
    // appears after that edge.
    always @(posedge clk) mem_data <= mw(mem_addr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Stream model: accepted words must be consecutive PCs from the
    // last reset/redirect target, each carrying its memory word.
    logic [31:0] exp_pc = 32'h0;
    bit          want_idle = 0;
    bit          stalled = 0;
    logic [31:0] stall_pc = '0;

    always @(negedge reset_n) begin
        exp_pc    = 32'h0;
        want_idle = 0;
        stalled   = 0;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (want_idle)
                chk("post-redirect valid", {31'b0, instr_valid}, 32'h0);
            if (stalled && !want_idle) begin
                chk("stall valid", {31'b0, instr_valid}, 32'h1);
                chk("stall pc", instr_pc, stall_pc);
            end
            want_idle = 0;
            stalled   = 0;
            if (redirect_valid) begin
                exp_pc    = redirect_pc & ~32'h3;
                want_idle = 1;
            end else if (instr_valid && instr_ready) begin
                chk("stream pc", instr_pc, exp_pc);
                chk("stream instr", instr, mw(exp_pc));
                exp_pc = exp_pc + 32'd4;
                accepts++;
            end else if (instr_valid) begin
                stalled  = 1;
                stall_pc = instr_pc;
            end
        end
    end

    typedef struct {
        bit          rst;
        bit          fe;
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] ei;
        logic [31:0] ea;
        bit          hd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input bit rst, input bit fe, input bit rdy, input bit rv,
        input logic [31:0] rpc, input bit ev, input logic [31:0] epc,
        input logic [31:0] ei, input logic [31:0] ea, input bit hd);
        vec_t v;
        v.rst = rst; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.ei = ei; v.ea = ea; v.hd = hd;
        return v;
    endfunction

    task automatic do_reset();
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        // streaming
        vecs.push_back(mk(1,1,1,0,0, 0,0,0,0,1));
        vecs.push_back(mk(0,1,1,0,0, 0,0,0,32'h4,0));
        vecs.push_back(mk(0,1,1,0,0, 1,32'h0,32'hA00000AA,32'h8,1));
        vecs.push_back(mk(0,1,1,0,0, 1,32'h4,32'h10000011,32'hC,1));
        vecs.push_back(mk(0,1,1,0,0, 1,32'h8,32'h20000022,32'h10,1));
        vecs.push_back(mk(0,1,1,0,0, 1,32'hC,32'h30000033,32'h14,1));
        // backpressure
        vecs.push_back(mk(1,1,1,0,0, 0,0,0,0,1));
        vecs.push_back(mk(0,1,0,0,0, 0,0,0,32'h4,0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0,1,0,0,0, 1,32'h0,32'hA00000AA,32'h8,1));
        vecs.push_back(mk(0,1,1,0,0, 1,32'h0,32'hA00000AA,32'h8,1));
        vecs.push_back(mk(0,1,1,0,0, 1,32'h4,32'h10000011,32'hC,1));
        vecs.push_back(mk(0,1,1,0,0, 1,32'h8,32'h20000022,32'h10,1));
        vecs.push_back(mk(0,1,1,0,0, 1,32'hC,32'h30000033,32'h14,1));
        // fetch_en toggling
        vecs.push_back(mk(1,1,1,0,0, 0,0,0,0,1));
        vecs.push_back(mk(0,1,1,0,0, 0,0,0,32'h4,0));
        vecs.push_back(mk(0,0,1,0,0, 1,32'h0,32'hA00000AA,32'h8,1));
        vecs.push_back(mk(0,0,1,0,0, 1,32'h4,32'h10000011,32'h8,1));
        vecs.push_back(mk(0,0,1,0,0, 0,32'h4,32'h10000011,32'h8,1));
        vecs.push_back(mk(0,0,1,0,0, 0,32'h4,32'h10000011,32'h8,1));
        vecs.push_back(mk(0,1,1,0,0, 0,32'h4,32'h10000011,32'h8,1));
        vecs.push_back(mk(0,1,1,0,0, 0,32'h4,32'h10000011,32'hC,1));
        vecs.push_back(mk(0,1,1,0,0, 1,32'h8,32'h20000022,32'h10,1));
        // redirect while 0x8 in flight
        vecs.push_back(mk(1,1,1,0,0, 0,0,0,0,1));
        vecs.push_back(mk(0,1,1,0,0, 0,0,0,32'h4,0));
        vecs.push_back(mk(0,1,1,0,0, 1,32'h0,32'hA00000AA,32'h8,1));
        vecs.push_back(mk(0,1,1,1,32'h26, 1,32'h4,32'h10000011,32'hC,1));
        vecs.push_back(mk(0,1,1,0,0, 0,0,0,32'h24,0));
        vecs.push_back(mk(0,1,1,0,0, 0,0,0,32'h28,0));
        vecs.push_back(mk(0,1,1,0,0, 1,32'h24,mw(32'h24),32'h2C,1));
        // wrap
        vecs.push_back(mk(1,1,1,1,32'hFFFF_FFFF, 0,0,0,0,1));
        vecs.push_back(mk(0,1,1,0,0, 0,0,0,32'hFFFF_FFFC,0));
        vecs.push_back(mk(0,1,1,0,0, 0,0,0,32'h0,0));
        vecs.push_back(mk(0,1,1,0,0, 1,32'hFFFF_FFFC,mw(32'hFFFF_FFFC),
                          32'h4,1));
        vecs.push_back(mk(0,1,1,0,0, 1,32'h0,32'hA00000AA,32'h8,1));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            chk($sformatf("r%0d valid", i), {31'b0, instr_valid},
                {31'b0, vecs[i].ev});
            chk($sformatf("r%0d mem_addr", i), mem_addr, vecs[i].ea);
            if (vecs[i].hd) begin
                chk($sformatf("r%0d instr_pc", i), instr_pc, vecs[i].epc);
                chk($sformatf("r%0d instr", i), instr, vecs[i].ei);
            end
            fetch_en       = vecs[i].fe;
            instr_ready    = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(posedge clk);
            #2;
        end

        // async reset with a full queue
        do_reset();
        fetch_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("full head valid", {31'b0, instr_valid}, 32'h1);
        chk("full mem_addr", mem_addr, 32'h8);
        #1 reset_n = 1'b0;
        #1;
        chk("arst valid", {31'b0, instr_valid}, 32'h0);
        chk("arst mem_addr", mem_addr, 32'h0);
        chk("arst instr", instr, 32'h0);
        chk("arst instr_pc", instr_pc, 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        instr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("restart valid", {31'b0, instr_valid}, 32'h1);
        chk("restart pc", instr_pc, 32'h0);
        chk("restart instr", instr, 32'hA00000AA);

        // random traffic against the stream model
        accepts = 0;
        for (int c = 0; c < 2000; c++) begin
            fetch_en       = ($urandom % 4) != 0;
            instr_ready    = ($urandom % 3) != 0;
            redirect_valid = ($urandom % 20) == 0;
            redirect_pc    = $urandom;
            @(posedge clk);
            #2;
        end
        redirect_valid = 1'b0;
        tests++;
        if (accepts < 300) begin
            fails++;
            $display("FAIL random throughput: got %0d accepts required >= 300",
                     accepts);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator for the word-addressed instruction memory.
- Generates the PC stream and drives the memory address.
- Captures read data arriving 1 cycle later (the memory registers its output) into a small instruction queue with valid/ready handshake toward decode.
- Supports pipeline redirect (branch/jump), which flushes queued and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, instruction queue entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- fetch_en  input  1  1 = issue new reads; 0 = hold PC, drain queue normally
- mem_addr  output  32  byte address to memory = pc_q; bits [1:0] always 0
- mem_data  input  32  memory read data, valid the cycle after the edge that sampled mem_addr
- redirect_valid  input  1  redirect request, sampled at rising edge
- redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0)
- instr_valid  output  1  queue head valid
- instr  output  32  queue head instruction word
- instr_pc  output  32  byte address of queue head
- instr_ready  input  1  decode accepts head when instr_valid & instr_ready

Behaviour:
- Reset (reset_n=0, async): pc_q=RESET_PC, inflight_q=0, queue empty.
  - instr_valid=0; instr=0; instr_pc=0; mem_addr=RESET_PC.
  - Reset mid-operation discards everything.
- mem_addr is combinational from pc_q only; no combinational path from any input.
- pop = instr_valid & instr_ready.
- issue = fetch_en & ~redirect_valid & ((occupancy + inflight_q − pop) < DEPTH).
  - The same-cycle pop credit is mandatory: it gives 1 instr/cycle steady state at DEPTH=2.
- On issue at edge E:
  - inflight_q←1, inflight_pc_q←pc_q, pc_q←pc_q+4.
  - 32-bit wrap: 32'hFFFF_FFFC+4 = 0.
- Without issue: inflight_q←0 and pc_q holds.
- Return: if inflight_q=1 at edge E+1, push {inflight_pc_q, mem_data} into the queue.
  - Push and pop in the same edge are both performed; occupancy unchanged.
  - The issue rule guarantees no push to a full queue; overflow is a design error (assertion).
- Read latency: first instr_valid rises 2 edges after reset_n release, given fetch_en=1, instr_ready irrelevant.
- Queue is FIFO order. instr and instr_pc reflect the head and stay stable while instr_valid & ~instr_ready.
- Redirect (redirect_valid=1 at edge) has priority over all other events:
  - Queue flushed (occupancy←0).
  - inflight_q←0; the returning word is dropped.
  - pc_q←{redirect_pc[31:2],2'b00}.
  - No issue that edge.
  - instr_valid=0 the following cycle. The first redirected instruction is valid 2 edges after the redirect edge.
  - A simultaneous pop is ignored by the flush.
  - Back-to-back redirects: the last one wins.
- fetch_en=0: no new issue. An in-flight word still lands; the queue still drains.
- When instr_valid=0, instr/instr_pc hold last popped/reset values. Decode must ignore them.
- Occupancy counter width: clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.

Test Plan:
- Memory model preloaded with word0=A00000AA, word1=10000011, word2=20000022, word3=30000033 (1-cycle registered read); reset, fetch_en=1, instr_ready=1.
  - Required: instr_valid rises on the 2nd edge after release.
  - Successive accepted pairs are (0,A00000AA), (4,10000011), (8,20000022), (C,30000033), one per cycle, no gaps.
- Backpressure: as above, instr_ready=0 for 4 cycles after the first valid.
  - Required: instr stays A00000AA with instr_pc=0; occupancy saturates at 2; mem_addr stalls at 0x8.
  - On release, words 0x0,0x4,0x8 arrive in order with none lost or duplicated.
- Redirect: during streaming, assert redirect_valid with redirect_pc=0x26 for one cycle while word 0x8 is in flight.
  - Required: 0x8 and any queued entries are never accepted; mem_addr becomes 0x24 next cycle.
  - The next valid, 2 edges later, is instr_pc=0x24.
- fetch_en toggling: fetch_en=0 after issuing 0x4.
  - Required: 0x4 still delivered; mem_addr holds 0x8; no further valid until fetch_en=1.
  - Then 0x8 follows after 2 edges.
- Async reset mid-stream with queue full.
  - Required: immediately (before the next edge) instr_valid=0, mem_addr=RESET_PC, instr=0, instr_pc=0.
  - After release, the sequence restarts from word0.
- Wrap: redirect to 0xFFFF_FFFC.
  - Required: the next issued address is 0x0000_0000 with the correct instr_pc.
